// File: rtl/addr_sel_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | addr_sel_pkg : shared widths, sizes and types for addr_sel          |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package addr_sel_pkg;
   localparam int ADDR_SERIAL_NUM_WIDTH = 7;
   localparam int SRAM_ADDR_WIDTH       = 10;
   localparam int NUM_LANES             = 32;
   localparam int DEPTH                 = 96;
   localparam int PORT_LANES            = 32;
   localparam logic [SRAM_ADDR_WIDTH-1:0] IDLE_ADDR = 10'h3FF;

   typedef logic [SRAM_ADDR_WIDTH-1:0]       sram_addr_t;
   typedef logic [ADDR_SERIAL_NUM_WIDTH-1:0] serial_num_t;
endpackage
`default_nettype wire

// File: rtl/addr_sel_lane.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | addr_sel_lane : one skewed read-address lane (window, offset, reg)  |
// | ADDR_SEL_IDLE_PARK_EN: park out-of-window lanes at IDLE_ADDR,       |
// | otherwise hold the last registered address.   Rev 1.0              |
// +--------------------------------------------------------------------+
module addr_sel_lane #(
   parameter int SN_WIDTH  = 7,
   parameter int AW        = 10,
   parameter int LANE_IDX  = 0,
   parameter int DEPTH     = 96,
   parameter int BASE      = 0,
   parameter logic [AW-1:0] IDLE_ADDR = '1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [SN_WIDTH-1:0] addr_serial_num,
   output logic [AW-1:0]       raddr
);
   import addr_sel_pkg::*;

   localparam int               LAST_I  = DEPTH - 1;
   localparam logic [SN_WIDTH:0]   WIN_LO  = LANE_IDX[SN_WIDTH:0];
   localparam logic [SN_WIDTH-1:0] K_LAST  = LAST_I[SN_WIDTH-1:0];
   localparam logic [AW-1:0]       BASE_A  = BASE[AW-1:0];

   logic [SN_WIDTH:0] diff;
   logic              active;
   logic [AW-1:0]     next_addr;

   // A borrow out of n - LANE_IDX means the window has not opened yet
   assign diff      = {1'b0, addr_serial_num} - WIN_LO;
   assign active    = !diff[SN_WIDTH] && (diff[SN_WIDTH-1:0] <= K_LAST);
   assign next_addr = BASE_A + AW'(diff[SN_WIDTH-1:0]);

   always_ff @(posedge clk) begin
      if (rst) begin
         raddr <= IDLE_ADDR;
      end else if (active) begin
         raddr <= next_addr;
      end
`ifdef ADDR_SEL_IDLE_PARK_EN
      else begin
         raddr <= IDLE_ADDR;
      end
`endif
   end
endmodule
`default_nettype wire

// File: rtl/addr_sel.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | addr_sel : wavefront read-address generator, 32 weight + 32 data    |
// | lanes. Macro ADDR_SEL_IDLE_PARK_EN selects park vs hold.  Rev 1.0   |
// +--------------------------------------------------------------------+
module addr_sel #(
   parameter int ADDR_SERIAL_NUM_WIDTH = addr_sel_pkg::ADDR_SERIAL_NUM_WIDTH,
   parameter int SRAM_ADDR_WIDTH       = addr_sel_pkg::SRAM_ADDR_WIDTH,
   parameter int NUM_LANES             = addr_sel_pkg::NUM_LANES,
   parameter int DEPTH                 = addr_sel_pkg::DEPTH,
   parameter int W_BASE                = 0,
   parameter int D_BASE                = 0,
   parameter logic [SRAM_ADDR_WIDTH-1:0] IDLE_ADDR = addr_sel_pkg::IDLE_ADDR
) (
   input  logic clk,
   input  logic rst,
   input  logic [ADDR_SERIAL_NUM_WIDTH-1:0] addr_serial_num,
   output logic [SRAM_ADDR_WIDTH-1:0] sram_raddr_w0,  sram_raddr_w1,  sram_raddr_w2,  sram_raddr_w3,
                                      sram_raddr_w4,  sram_raddr_w5,  sram_raddr_w6,  sram_raddr_w7,
                                      sram_raddr_w8,  sram_raddr_w9,  sram_raddr_w10, sram_raddr_w11,
                                      sram_raddr_w12, sram_raddr_w13, sram_raddr_w14, sram_raddr_w15,
                                      sram_raddr_w16, sram_raddr_w17, sram_raddr_w18, sram_raddr_w19,
                                      sram_raddr_w20, sram_raddr_w21, sram_raddr_w22, sram_raddr_w23,
                                      sram_raddr_w24, sram_raddr_w25, sram_raddr_w26, sram_raddr_w27,
                                      sram_raddr_w28, sram_raddr_w29, sram_raddr_w30, sram_raddr_w31,
   output logic [SRAM_ADDR_WIDTH-1:0] sram_raddr_d0,  sram_raddr_d1,  sram_raddr_d2,  sram_raddr_d3,
                                      sram_raddr_d4,  sram_raddr_d5,  sram_raddr_d6,  sram_raddr_d7,
                                      sram_raddr_d8,  sram_raddr_d9,  sram_raddr_d10, sram_raddr_d11,
                                      sram_raddr_d12, sram_raddr_d13, sram_raddr_d14, sram_raddr_d15,
                                      sram_raddr_d16, sram_raddr_d17, sram_raddr_d18, sram_raddr_d19,
                                      sram_raddr_d20, sram_raddr_d21, sram_raddr_d22, sram_raddr_d23,
                                      sram_raddr_d24, sram_raddr_d25, sram_raddr_d26, sram_raddr_d27,
                                      sram_raddr_d28, sram_raddr_d29, sram_raddr_d30, sram_raddr_d31
);
   import addr_sel_pkg::*;

   logic [SRAM_ADDR_WIDTH-1:0] w_addr [PORT_LANES];
   logic [SRAM_ADDR_WIDTH-1:0] d_addr [PORT_LANES];

   // Port list is fixed at 32 lanes; lanes beyond NUM_LANES are tied idle
   for (genvar i = 0; i < PORT_LANES; i++) begin : g_lane
      if (i < NUM_LANES) begin : g_act
         addr_sel_lane #(
            .SN_WIDTH(ADDR_SERIAL_NUM_WIDTH), .AW(SRAM_ADDR_WIDTH), .LANE_IDX(i),
            .DEPTH(DEPTH), .BASE(W_BASE), .IDLE_ADDR(IDLE_ADDR)
         ) u_w (
            .clk(clk), .rst(rst), .addr_serial_num(addr_serial_num), .raddr(w_addr[i])
         );
         addr_sel_lane #(
            .SN_WIDTH(ADDR_SERIAL_NUM_WIDTH), .AW(SRAM_ADDR_WIDTH), .LANE_IDX(i),
            .DEPTH(DEPTH), .BASE(D_BASE), .IDLE_ADDR(IDLE_ADDR)
         ) u_d (
            .clk(clk), .rst(rst), .addr_serial_num(addr_serial_num), .raddr(d_addr[i])
         );
      end else begin : g_off
         assign w_addr[i] = IDLE_ADDR;
         assign d_addr[i] = IDLE_ADDR;
      end
   end

   assign sram_raddr_w0  = w_addr[0];  assign sram_raddr_w1  = w_addr[1];
   assign sram_raddr_w2  = w_addr[2];  assign sram_raddr_w3  = w_addr[3];
   assign sram_raddr_w4  = w_addr[4];  assign sram_raddr_w5  = w_addr[5];
   assign sram_raddr_w6  = w_addr[6];  assign sram_raddr_w7  = w_addr[7];
   assign sram_raddr_w8  = w_addr[8];  assign sram_raddr_w9  = w_addr[9];
   assign sram_raddr_w10 = w_addr[10]; assign sram_raddr_w11 = w_addr[11];
   assign sram_raddr_w12 = w_addr[12]; assign sram_raddr_w13 = w_addr[13];
   assign sram_raddr_w14 = w_addr[14]; assign sram_raddr_w15 = w_addr[15];
   assign sram_raddr_w16 = w_addr[16]; assign sram_raddr_w17 = w_addr[17];
   assign sram_raddr_w18 = w_addr[18]; assign sram_raddr_w19 = w_addr[19];
   assign sram_raddr_w20 = w_addr[20]; assign sram_raddr_w21 = w_addr[21];
   assign sram_raddr_w22 = w_addr[22]; assign sram_raddr_w23 = w_addr[23];
   assign sram_raddr_w24 = w_addr[24]; assign sram_raddr_w25 = w_addr[25];
   assign sram_raddr_w26 = w_addr[26]; assign sram_raddr_w27 = w_addr[27];
   assign sram_raddr_w28 = w_addr[28]; assign sram_raddr_w29 = w_addr[29];
   assign sram_raddr_w30 = w_addr[30]; assign sram_raddr_w31 = w_addr[31];

   assign sram_raddr_d0  = d_addr[0];  assign sram_raddr_d1  = d_addr[1];
   assign sram_raddr_d2  = d_addr[2];  assign sram_raddr_d3  = d_addr[3];
   assign sram_raddr_d4  = d_addr[4];  assign sram_raddr_d5  = d_addr[5];
   assign sram_raddr_d6  = d_addr[6];  assign sram_raddr_d7  = d_addr[7];
   assign sram_raddr_d8  = d_addr[8];  assign sram_raddr_d9  = d_addr[9];
   assign sram_raddr_d10 = d_addr[10]; assign sram_raddr_d11 = d_addr[11];
   assign sram_raddr_d12 = d_addr[12]; assign sram_raddr_d13 = d_addr[13];
   assign sram_raddr_d14 = d_addr[14]; assign sram_raddr_d15 = d_addr[15];
   assign sram_raddr_d16 = d_addr[16]; assign sram_raddr_d17 = d_addr[17];
   assign sram_raddr_d18 = d_addr[18]; assign sram_raddr_d19 = d_addr[19];
   assign sram_raddr_d20 = d_addr[20]; assign sram_raddr_d21 = d_addr[21];
   assign sram_raddr_d22 = d_addr[22]; assign sram_raddr_d23 = d_addr[23];
   assign sram_raddr_d24 = d_addr[24]; assign sram_raddr_d25 = d_addr[25];
   assign sram_raddr_d26 = d_addr[26]; assign sram_raddr_d27 = d_addr[27];
   assign sram_raddr_d28 = d_addr[28]; assign sram_raddr_d29 = d_addr[29];
   assign sram_raddr_d30 = d_addr[30]; assign sram_raddr_d31 = d_addr[31];
endmodule
`default_nettype wire

// File: tb/tb_addr_sel.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_addr_sel : directed vector table plus base-offset sweep for      |
// | addr_sel, in either ADDR_SEL_IDLE_PARK_EN build.   Rev 1.0          |
// +--------------------------------------------------------------------+
module tb_addr_sel;
   import addr_sel_pkg::*;

`ifdef ADDR_SEL_IDLE_PARK_EN
   localparam bit PARK = 1'b1;
`else
   localparam bit PARK = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] sn  = 7'd0;
   sram_addr_t ow [2][32];
   sram_addr_t od [2][32];
   sram_addr_t mw [2][32];
   sram_addr_t md [2][32];
   int         wbase [2] = '{0, 'h100};
   int         dbase [2] = '{0, 'h200};
   int         n_tests = 0;
   int         n_fail  = 0;

   always #5 clk = ~clk;

   addr_sel u_a (
      .clk(clk), .rst(rst), .addr_serial_num(sn),
      .sram_raddr_w0(ow[0][0]),   .sram_raddr_w1(ow[0][1]),   .sram_raddr_w2(ow[0][2]),   .sram_raddr_w3(ow[0][3]),
      .sram_raddr_w4(ow[0][4]),   .sram_raddr_w5(ow[0][5]),   .sram_raddr_w6(ow[0][6]),   .sram_raddr_w7(ow[0][7]),
      .sram_raddr_w8(ow[0][8]),   .sram_raddr_w9(ow[0][9]),   .sram_raddr_w10(ow[0][10]), .sram_raddr_w11(ow[0][11]),
      .sram_raddr_w12(ow[0][12]), .sram_raddr_w13(ow[0][13]), .sram_raddr_w14(ow[0][14]), .sram_raddr_w15(ow[0][15]),
      .sram_raddr_w16(ow[0][16]), .sram_raddr_w17(ow[0][17]), .sram_raddr_w18(ow[0][18]), .sram_raddr_w19(ow[0][19]),
      .sram_raddr_w20(ow[0][20]), .sram_raddr_w21(ow[0][21]), .sram_raddr_w22(ow[0][22]), .sram_raddr_w23(ow[0][23]),
      .sram_raddr_w24(ow[0][24]), .sram_raddr_w25(ow[0][25]), .sram_raddr_w26(ow[0][26]), .sram_raddr_w27(ow[0][27]),
      .sram_raddr_w28(ow[0][28]), .sram_raddr_w29(ow[0][29]), .sram_raddr_w30(ow[0][30]), .sram_raddr_w31(ow[0][31]),
      .sram_raddr_d0(od[0][0]),   .sram_raddr_d1(od[0][1]),   .sram_raddr_d2(od[0][2]),   .sram_raddr_d3(od[0][3]),
      .sram_raddr_d4(od[0][4]),   .sram_raddr_d5(od[0][5]),   .sram_raddr_d6(od[0][6]),   .sram_raddr_d7(od[0][7]),
      .sram_raddr_d8(od[0][8]),   .sram_raddr_d9(od[0][9]),   .sram_raddr_d10(od[0][10]), .sram_raddr_d11(od[0][11]),
      .sram_raddr_d12(od[0][12]), .sram_raddr_d13(od[0][13]), .sram_raddr_d14(od[0][14]), .sram_raddr_d15(od[0][15]),
      .sram_raddr_d16(od[0][16]), .sram_raddr_d17(od[0][17]), .sram_raddr_d18(od[0][18]), .sram_raddr_d19(od[0][19]),
      .sram_raddr_d20(od[0][20]), .sram_raddr_d21(od[0][21]), .sram_raddr_d22(od[0][22]), .sram_raddr_d23(od[0][23]),
      .sram_raddr_d24(od[0][24]), .sram_raddr_d25(od[0][25]), .sram_raddr_d26(od[0][26]), .sram_raddr_d27(od[0][27]),
      .sram_raddr_d28(od[0][28]), .sram_raddr_d29(od[0][29]), .sram_raddr_d30(od[0][30]), .sram_raddr_d31(od[0][31])
   );

   addr_sel #(.W_BASE('h100), .D_BASE('h200)) u_b (
      .clk(clk), .rst(rst), .addr_serial_num(sn),
      .sram_raddr_w0(ow[1][0]),   .sram_raddr_w1(ow[1][1]),   .sram_raddr_w2(ow[1][2]),   .sram_raddr_w3(ow[1][3]),
      .sram_raddr_w4(ow[1][4]),   .sram_raddr_w5(ow[1][5]),   .sram_raddr_w6(ow[1][6]),   .sram_raddr_w7(ow[1][7]),
      .sram_raddr_w8(ow[1][8]),   .sram_raddr_w9(ow[1][9]),   .sram_raddr_w10(ow[1][10]), .sram_raddr_w11(ow[1][11]),
      .sram_raddr_w12(ow[1][12]), .sram_raddr_w13(ow[1][13]), .sram_raddr_w14(ow[1][14]), .sram_raddr_w15(ow[1][15]),
      .sram_raddr_w16(ow[1][16]), .sram_raddr_w17(ow[1][17]), .sram_raddr_w18(ow[1][18]), .sram_raddr_w19(ow[1][19]),
      .sram_raddr_w20(ow[1][20]), .sram_raddr_w21(ow[1][21]), .sram_raddr_w22(ow[1][22]), .sram_raddr_w23(ow[1][23]),
      .sram_raddr_w24(ow[1][24]), .sram_raddr_w25(ow[1][25]), .sram_raddr_w26(ow[1][26]), .sram_raddr_w27(ow[1][27]),
      .sram_raddr_w28(ow[1][28]), .sram_raddr_w29(ow[1][29]), .sram_raddr_w30(ow[1][30]), .sram_raddr_w31(ow[1][31]),
      .sram_raddr_d0(od[1][0]),   .sram_raddr_d1(od[1][1]),   .sram_raddr_d2(od[1][2]),   .sram_raddr_d3(od[1][3]),
      .sram_raddr_d4(od[1][4]),   .sram_raddr_d5(od[1][5]),   .sram_raddr_d6(od[1][6]),   .sram_raddr_d7(od[1][7]),
      .sram_raddr_d8(od[1][8]),   .sram_raddr_d9(od[1][9]),   .sram_raddr_d10(od[1][10]), .sram_raddr_d11(od[1][11]),
      .sram_raddr_d12(od[1][12]), .sram_raddr_d13(od[1][13]), .sram_raddr_d14(od[1][14]), .sram_raddr_d15(od[1][15]),
      .sram_raddr_d16(od[1][16]), .sram_raddr_d17(od[1][17]), .sram_raddr_d18(od[1][18]), .sram_raddr_d19(od[1][19]),
      .sram_raddr_d20(od[1][20]), .sram_raddr_d21(od[1][21]), .sram_raddr_d22(od[1][22]), .sram_raddr_d23(od[1][23]),
      .sram_raddr_d24(od[1][24]), .sram_raddr_d25(od[1][25]), .sram_raddr_d26(od[1][26]), .sram_raddr_d27(od[1][27]),
      .sram_raddr_d28(od[1][28]), .sram_raddr_d29(od[1][29]), .sram_raddr_d30(od[1][30]), .sram_raddr_d31(od[1][31])
   );

   typedef struct {
      bit         r;
      int         n;
      int         lane;
      sram_addr_t exp;
   } vec_t;

   task automatic check(input string name, input sram_addr_t got, input sram_addr_t exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   // Reference behaviour: reset -> idle, in-window -> base + (n - lane), else park or hold
   task automatic model_step(input bit r, input int n);
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 32; i++) begin
            int k;
            k = n - i;
            if (r) begin
               mw[s][i] = 10'h3FF;
               md[s][i] = 10'h3FF;
            end else if (k >= 0 && k <= 95) begin
               mw[s][i] = 10'((wbase[s] + k) % 1024);
               md[s][i] = 10'((dbase[s] + k) % 1024);
            end else if (PARK) begin
               mw[s][i] = 10'h3FF;
               md[s][i] = 10'h3FF;
            end
         end
      end
   endtask

   task automatic check_model(input int s);
      int bad;
      bad = -1;
      for (int i = 0; i < 32; i++)
         if (bad < 0 && (ow[s][i] !== mw[s][i] || od[s][i] !== md[s][i])) bad = i;
      n_tests++;
      if (bad >= 0) begin
         n_fail++;
         $display("FAIL model_dut%0d lane %0d n=%0d: got w=%h d=%h, expected w=%h d=%h",
                  s, bad, sn, ow[s][bad], od[s][bad], mw[s][bad], md[s][bad]);
      end
   endtask

   task automatic step(input bit r, input int n);
      @(negedge clk);
      rst = r;
      sn  = 7'(n);
      @(posedge clk);
      #1;
      model_step(r, n);
      check_model(0);
      check_model(1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t vecs[$];
      for (int s = 0; s < 2; s++)
         for (int i = 0; i < 32; i++) begin
            mw[s][i] = 10'h3FF;
            md[s][i] = 10'h3FF;
         end

      vecs.push_back('{1'b1, 0,   0,  10'h3FF});
      vecs.push_back('{1'b1, 0,   31, 10'h3FF});
      vecs.push_back('{1'b0, 0,   0,  10'h000});
      vecs.push_back('{1'b0, 0,   1,  10'h3FF});
      vecs.push_back('{1'b0, 0,   31, 10'h3FF});
      vecs.push_back('{1'b0, 31,  0,  10'h01F});
      vecs.push_back('{1'b0, 31,  1,  10'h01E});
      vecs.push_back('{1'b0, 31,  15, 10'h010});
      vecs.push_back('{1'b0, 31,  31, 10'h000});
      vecs.push_back('{1'b0, 98,  0,  PARK ? 10'h3FF : 10'h01F});
      vecs.push_back('{1'b0, 98,  1,  PARK ? 10'h3FF : 10'h01E});
      vecs.push_back('{1'b0, 98,  2,  PARK ? 10'h3FF : 10'h01D});
      vecs.push_back('{1'b0, 98,  3,  10'h05F});
      vecs.push_back('{1'b0, 98,  15, 10'h053});
      vecs.push_back('{1'b0, 98,  31, 10'h043});
      vecs.push_back('{1'b0, 126, 31, 10'h05F});
      vecs.push_back('{1'b0, 126, 30, PARK ? 10'h3FF : 10'h044});
      vecs.push_back('{1'b0, 126, 0,  PARK ? 10'h3FF : 10'h01F});
      vecs.push_back('{1'b0, 127, 31, PARK ? 10'h3FF : 10'h05F});
      vecs.push_back('{1'b1, 127, 31, 10'h3FF});
      vecs.push_back('{1'b0, 95,  0,  10'h05F});
      vecs.push_back('{1'b0, 95,  31, 10'h040});
      vecs.push_back('{1'b0, 96,  0,  PARK ? 10'h3FF : 10'h05F});
      vecs.push_back('{1'b0, 96,  1,  10'h05F});

      for (int v = 0; v < vecs.size(); v++) begin
         step(vecs[v].r, vecs[v].n);
         check($sformatf("vec%0d_w%0d", v, vecs[v].lane), ow[0][vecs[v].lane], vecs[v].exp);
         check($sformatf("vec%0d_d%0d", v, vecs[v].lane), od[0][vecs[v].lane], vecs[v].exp);
      end

      // Based sweep with a mid-sweep reset, then a backward jump
      for (int n = 0; n <= 126; n++) begin
         if (n == 62) begin
            step(1'b1, 62);
            check("rst62_w0", ow[1][0], 10'h3FF);
            check("rst62_d31", od[1][31], 10'h3FF);
            step(1'b0, 62);
            check("post_rst_w0", ow[1][0], 10'h13E);
            check("post_rst_d0", od[1][0], 10'h23E);
         end else begin
            step(1'b0, n);
         end
         if (n == 40) begin
            check("sweep40_w10", ow[1][10], 10'h11E);
            check("sweep40_d10", od[1][10], 10'h21E);
         end
      end
      check("sweep126_w31", ow[1][31], 10'h15F);
      check("sweep126_d31", od[1][31], 10'h25F);
      step(1'b0, 5);
      check("jump5_w3", ow[1][3], 10'h102);
      check("jump5_d3", od[1][3], 10'h202);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
